// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the main-RAM sequencer.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_TAIL,
    WR1,
    WR2,
    DONE
  } state_t;

  // The RAM burst length is fixed; only 4 words per line is legal.
  localparam int LINE_WORDS = 4;
  localparam int BEAT_W     = 2;

  // Line reads are aligned to 16 bytes, word writes to 4 bytes.
  localparam logic [31:0] LINE_MASK = ~32'hF;
  localparam logic [31:0] WORD_MASK = ~32'h3;

  // Every read is exactly RD_BEATS MRd-low cycles and every write exactly
  // WR_CYCLES CMWr-high cycles, which keeps the RAM's beat counter aligned.
  localparam int RD_BEATS  = 4;
  localparam int WR_CYCLES = 2;

endpackage

// File: rtl/mem_seq_if.sv
// Port and RAM-side signal bundle for mem_seq.
interface mem_seq_if #(
  parameter int ADDR_W = 32
);

  logic              P0_REQ;
  logic              P0_WE;
  logic [ADDR_W-1:0] P0_ADDR;
  logic [31:0]       P0_WDATA;
  logic              P0_ACK;

  logic              P1_REQ;
  logic              P1_WE;
  logic [ADDR_W-1:0] P1_ADDR;
  logic [31:0]       P1_WDATA;
  logic              P1_ACK;

  logic [127:0]      LINE_DATA;
  logic              BUSY;

  logic              MRd;
  logic              CMWr;
  logic [ADDR_W-1:0] AB;
  logic [31:0]       MD_IN;
  logic [31:0]       MD_OUT;
  logic              MD_OE;

  // Requesters and the RAM: drive requests and read data, observe the rest.
  modport master (
    output P0_REQ, P0_WE, P0_ADDR, P0_WDATA,
    output P1_REQ, P1_WE, P1_ADDR, P1_WDATA,
    output MD_IN,
    input  P0_ACK, P1_ACK, LINE_DATA, BUSY,
    input  MRd, CMWr, AB, MD_OUT, MD_OE
  );

  // The sequencer itself.
  modport slave (
    input  P0_REQ, P0_WE, P0_ADDR, P0_WDATA,
    input  P1_REQ, P1_WE, P1_ADDR, P1_WDATA,
    input  MD_IN,
    output P0_ACK, P1_ACK, LINE_DATA, BUSY,
    output MRd, CMWr, AB, MD_OUT, MD_OE
  );

endinterface

// File: rtl/mem_seq_rr_arb2.sv
// Two-requester arbiter: round-robin, or fixed priority to port 0.
module rr_arb2 #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = port 1 was granted last; resets to 1 so port 0 wins the first tie.
  logic last_reg;

  generate
    if (FIXED_PRI) begin : g_fixed
      // Port 0 always wins a tie.
      always_comb begin
        gnt = {req[1] & ~req[0], req[0]};
      end
    end else begin : g_rr
      // On a tie grant the port that was not granted last.
      always_comb begin
        gnt = req;
        if (req == 2'b11) begin
          gnt = last_reg ? 2'b01 : 2'b10;
        end
      end
    end
  endgenerate

  // Remember the winner whenever a grant is actually taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_reg <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_seq.sv
// Two-port line-read / word-write sequencer in front of the burst main RAM.
module mem_seq #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter bit FIXED_PRI  = 1'b0
) (
  input  logic      CLK,
  input  logic      RST,
  mem_seq_if.slave  bus
);

  import mem_seq_pkg::*;

  localparam logic [ADDR_W-1:0] AB_LINE_MASK = ~ADDR_W'(~LINE_MASK);
  localparam logic [ADDR_W-1:0] AB_WORD_MASK = ~ADDR_W'(~WORD_MASK);

  state_t                    state_reg;
  logic [BEAT_W-1:0]         beat_reg;
  logic                      port_reg;
  logic [31:0]               wdata_reg;
  logic [31:0]               buf_reg [LINE_WORDS-1];
  logic [32*LINE_WORDS-1:0]  line_reg;
  logic [32*LINE_WORDS-1:0]  line_next;
  logic                      mrd_reg;
  logic                      cmwr_reg;
  logic [ADDR_W-1:0]         ab_reg;
  logic [31:0]               md_out_reg;
  logic                      md_oe_reg;
  logic                      ack0_reg;
  logic                      ack1_reg;

  logic [1:0]                req;
  logic [1:0]                gnt;
  logic                      advance;
  logic                      sel_we;
  logic [ADDR_W-1:0]         sel_addr;
  logic [31:0]               sel_wdata;

  assign req     = {bus.P1_REQ, bus.P0_REQ};
  assign advance = (state_reg == IDLE);

  rr_arb2 #(
    .FIXED_PRI (FIXED_PRI)
  ) u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  assign sel_we    = gnt[1] ? bus.P1_WE    : bus.P0_WE;
  assign sel_addr  = gnt[1] ? bus.P1_ADDR  : bus.P0_ADDR;
  assign sel_wdata = gnt[1] ? bus.P1_WDATA : bus.P0_WDATA;

  // The completed line is the buffered words plus the last word on MD.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS - 1; gi++) begin : g_slot
      assign line_next[32*gi +: 32] = buf_reg[gi];
    end
  endgenerate
  assign line_next[32*(LINE_WORDS-1) +: 32] = bus.MD_IN;

  // Word k of the burst is on MD during beat k+1, so capture lags by one.
  always_ff @(posedge CLK) begin
    if (state_reg == RD && beat_reg != '0) begin
      buf_reg[beat_reg - 1'b1] <= bus.MD_IN;
    end
  end

  // Main sequencer: arbitrate, run one fixed-length RAM cycle, pulse ACK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      port_reg   <= 1'b0;
      wdata_reg  <= '0;
      line_reg   <= '0;
      mrd_reg    <= 1'b1;
      cmwr_reg   <= 1'b0;
      ab_reg     <= '0;
      md_out_reg <= '0;
      md_oe_reg  <= 1'b0;
      ack0_reg   <= 1'b0;
      ack1_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (gnt != 2'b00) begin
            port_reg  <= gnt[1];
            wdata_reg <= sel_wdata;
            beat_reg  <= '0;
            if (sel_we) begin
              state_reg <= WR1;
              ab_reg    <= sel_addr & AB_WORD_MASK;
              cmwr_reg  <= 1'b1;
              md_oe_reg <= 1'b0;
            end else begin
              state_reg <= RD;
              ab_reg    <= sel_addr & AB_LINE_MASK;
              mrd_reg   <= 1'b0;
            end
          end
        end
        RD: begin
          beat_reg <= beat_reg + 1'b1;
          if (beat_reg == BEAT_W'(RD_BEATS - 1)) begin
            state_reg <= RD_TAIL;
            mrd_reg   <= 1'b1;
          end
        end
        RD_TAIL: begin
          line_reg  <= line_next;
          state_reg <= DONE;
          ack0_reg  <= ~port_reg;
          ack1_reg  <= port_reg;
        end
        WR1: begin
          // The RAM is still releasing MD this cycle; drive only from WR2.
          state_reg  <= WR2;
          md_oe_reg  <= 1'b1;
          md_out_reg <= wdata_reg;
        end
        WR2: begin
          state_reg <= DONE;
          cmwr_reg  <= 1'b0;
          md_oe_reg <= 1'b0;
          ack0_reg  <= ~port_reg;
          ack1_reg  <= port_reg;
        end
        DONE: begin
          ack0_reg  <= 1'b0;
          ack1_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.P0_ACK    = ack0_reg;
  assign bus.P1_ACK    = ack1_reg;
  assign bus.LINE_DATA = line_reg;
  assign bus.BUSY      = (state_reg != IDLE);
  assign bus.MRd       = mrd_reg;
  assign bus.CMWr      = cmwr_reg;
  assign bus.AB        = ab_reg;
  assign bus.MD_OUT    = md_out_reg;
  assign bus.MD_OE     = md_oe_reg;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq with a small burst-RAM model.
module tb_mem_seq;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  mem_seq_if bus ();

  mem_seq dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- RAM model ----------------
  logic [31:0] mem [logic [31:0]];
  logic [1:0]  rbeat;
  logic        wbeat;
  logic        ram_reload;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Burst read: word k appears on MD after the (k+1)th MRd-low edge.
  // Write: the second CMWr-high edge stores MD_OUT.
  always @(posedge CLK) begin
    if (ram_reload) begin
      mem.delete();
      for (int i = 0; i < 8; i++) mem[32'(i * 4)] = 32'(i + 1);
      for (int i = 0; i < 4; i++) mem[32'h40020 + 32'(i * 4)] = 32'(9 + i);
      mem[32'h34] = 32'd6;
      mem[32'h38] = 32'd7;
      mem[32'h3C] = 32'd8;
      rbeat <= 2'd0;
      wbeat <= 1'b0;
      bus.MD_IN <= 32'h0;
    end else begin
      if (!bus.MRd) begin
        bus.MD_IN <= rd_word(bus.AB + {28'd0, rbeat, 2'b00});
        rbeat <= rbeat + 2'd1;
      end
      if (bus.CMWr) begin
        if (wbeat && bus.MD_OE) mem[bus.AB] = bus.MD_OUT;
        wbeat <= ~wbeat;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Per-run observations; cycle 1 is the sample just after the grant edge.
  int           p0_cyc[$];
  int           p1_cyc[$];
  logic [127:0] p0_line[$];
  logic [127:0] p1_line[$];
  int           mrd_low;
  int           cmwr_cnt;
  int           oe_cnt;
  int           oe_early;
  logic [31:0]  md_seen;
  logic [31:0]  ab_first;
  logic         busy_first;

  // Run until port 0 has seen want0 ACKs and port 1 want1, dropping each
  // REQ in its final ACK cycle; then step once more into IDLE.
  task automatic run(input int want0, input int want1, input int max);
    p0_cyc.delete(); p1_cyc.delete(); p0_line.delete(); p1_line.delete();
    mrd_low = 0; cmwr_cnt = 0; oe_cnt = 0; oe_early = 0;
    md_seen = 32'h0; ab_first = 32'h0; busy_first = 1'b0;
    for (int cyc = 1; cyc <= max; cyc++) begin
      tick();
      if (cyc == 1) begin
        ab_first   = bus.AB;
        busy_first = bus.BUSY;
      end
      if (!bus.MRd) mrd_low++;
      if (bus.CMWr) begin
        cmwr_cnt++;
        if (cmwr_cnt == 1 && bus.MD_OE) oe_early++;
      end
      if (bus.MD_OE) begin
        oe_cnt++;
        md_seen = bus.MD_OUT;
      end
      if (bus.P0_ACK) begin
        p0_cyc.push_back(cyc);
        p0_line.push_back(bus.LINE_DATA);
        if (p0_cyc.size() >= want0) bus.P0_REQ = 1'b0;
      end
      if (bus.P1_ACK) begin
        p1_cyc.push_back(cyc);
        p1_line.push_back(bus.LINE_DATA);
        if (p1_cyc.size() >= want1) bus.P1_REQ = 1'b0;
      end
      if (p0_cyc.size() >= want0 && p1_cyc.size() >= want1) break;
    end
    bus.P0_REQ = 1'b0;
    bus.P1_REQ = 1'b0;
    tick();
  endtask

  function automatic int qi(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  function automatic logic [127:0] ql(input logic [127:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 128'hx;
  endfunction

  task automatic req0(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.P0_WE = we; bus.P0_ADDR = addr; bus.P0_WDATA = wd; bus.P0_REQ = 1'b1;
  endtask

  task automatic req1(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.P1_WE = we; bus.P1_ADDR = addr; bus.P1_WDATA = wd; bus.P1_REQ = 1'b1;
  endtask

  initial begin
    ram_reload = 1'b1;
    bus.P0_REQ = 1'b0; bus.P0_WE = 1'b0; bus.P0_ADDR = 32'h0; bus.P0_WDATA = 32'h0;
    bus.P1_REQ = 1'b0; bus.P1_WE = 1'b0; bus.P1_ADDR = 32'h0; bus.P1_WDATA = 32'h0;
    RST = 1'b1;
    tick(); tick();

    // Reset state, with a request present while RST is high.
    req0(1'b0, 32'h14, 32'h0);
    tick();
    check("rst_mrd",   bus.MRd, 1'b1);
    check("rst_cmwr",  bus.CMWr, 1'b0);
    check("rst_ab",    bus.AB, 32'h0);
    check("rst_mdout", bus.MD_OUT, 32'h0);
    check("rst_mdoe",  bus.MD_OE, 1'b0);
    check("rst_acks",  {bus.P0_ACK, bus.P1_ACK}, 2'b00);
    check("rst_line",  bus.LINE_DATA, 128'h0);
    check("rst_busy",  bus.BUSY, 1'b0);
    bus.P0_REQ = 1'b0;
    RST = 1'b0;
    ram_reload = 1'b0;
    tick();
    check("rst_no_grant", bus.BUSY, 1'b0);

    // P0 line read of 0x14.
    req0(1'b0, 32'h14, 32'h0);
    run(1, 0, 20);
    $display("txn P0 RD 0x14 ack@%0d line=%h", qi(p0_cyc, 0), ql(p0_line, 0));
    check("rd0_ab",     ab_first, 32'h10);
    check("rd0_busy",   busy_first, 1'b1);
    check("rd0_mrdlow", mrd_low, 4);
    check("rd0_ackcyc", qi(p0_cyc, 0), 6);
    check("rd0_line",   ql(p0_line, 0), {32'd8, 32'd7, 32'd6, 32'd5});
    check("rd0_p1ack",  p1_cyc.size(), 0);

    // P1 line read of 0x4002C.
    req1(1'b0, 32'h4002C, 32'h0);
    run(0, 1, 20);
    $display("txn P1 RD 0x4002C ack@%0d line=%h", qi(p1_cyc, 0), ql(p1_line, 0));
    check("rd1_ab",     ab_first, 32'h40020);
    check("rd1_ackcyc", qi(p1_cyc, 0), 6);
    check("rd1_line",   ql(p1_line, 0), {32'd12, 32'd11, 32'd10, 32'd9});
    check("rd1_p0ack",  p0_cyc.size(), 0);

    // P1 word write then read-back.
    req1(1'b1, 32'h30, 32'hDEADBEEF);
    run(0, 1, 20);
    $display("txn P1 WR 0x30 ack@%0d cmwr=%0d oe=%0d", qi(p1_cyc, 0), cmwr_cnt, oe_cnt);
    check("wr_ab",      ab_first, 32'h30);
    check("wr_ackcyc",  qi(p1_cyc, 0), 3);
    check("wr_cmwr",    cmwr_cnt, 2);
    check("wr_oe",      oe_cnt, 1);
    check("wr_oe_1st",  oe_early, 0);
    check("wr_mdout",   md_seen, 32'hDEADBEEF);
    check("wr_mrdlow",  mrd_low, 0);
    req1(1'b0, 32'h30, 32'h0);
    run(0, 1, 20);
    $display("txn P1 RD 0x30 ack@%0d line=%h", qi(p1_cyc, 0), ql(p1_line, 0));
    check("rdbk_line",  ql(p1_line, 0), {32'd8, 32'd7, 32'd6, 32'hDEADBEEF});

    // Simultaneous reads right after reset: P0 first, P1 one IDLE cycle later.
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();
    req0(1'b0, 32'h0, 32'h0);
    req1(1'b0, 32'h10, 32'h0);
    run(1, 1, 40);
    $display("txn P0+P1 RD p0ack@%0d p1ack@%0d", qi(p0_cyc, 0), qi(p1_cyc, 0));
    check("tie_p0cyc",  qi(p0_cyc, 0), 6);
    check("tie_p1cyc",  qi(p1_cyc, 0), 13);
    check("tie_p0line", ql(p0_line, 0), {32'd4, 32'd3, 32'd2, 32'd1});
    check("tie_p1line", ql(p1_line, 0), {32'd8, 32'd7, 32'd6, 32'd5});

    // P0 requests continuously, P1 once: grants alternate P0, P1, P0.
    req0(1'b0, 32'h0, 32'h0);
    req1(1'b0, 32'h4002C, 32'h0);
    run(2, 1, 60);
    $display("txn RR p0ack@%0d,%0d p1ack@%0d", qi(p0_cyc, 0), qi(p0_cyc, 1), qi(p1_cyc, 0));
    check("rr_p0a",    qi(p0_cyc, 0), 6);
    check("rr_p1",     qi(p1_cyc, 0), 13);
    check("rr_p0b",    qi(p0_cyc, 1), 20);
    check("rr_p1line", ql(p1_line, 0), {32'd12, 32'd11, 32'd10, 32'd9});
    check("rr_p0line", ql(p0_line, 1), {32'd4, 32'd3, 32'd2, 32'd1});

    // Reset during the second RD cycle aborts with no ACK.
    req0(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    $display("txn P0 RD aborted busy=%0b mrd=%0b", bus.BUSY, bus.MRd);
    check("abort_busy", bus.BUSY, 1'b0);
    check("abort_mrd",  bus.MRd, 1'b1);
    check("abort_ack",  {bus.P0_ACK, bus.P1_ACK}, 2'b00);
    bus.P0_REQ = 1'b0;
    RST = 1'b0;
    ram_reload = 1'b1;
    tick();
    ram_reload = 1'b0;
    tick();
    check("abort_idle_ack", bus.P0_ACK, 1'b0);
    req0(1'b0, 32'h0, 32'h0);
    run(1, 0, 20);
    $display("txn P0 RD 0x0 ack@%0d line=%h", qi(p0_cyc, 0), ql(p0_line, 0));
    check("reload_cyc",  qi(p0_cyc, 0), 6);
    check("reload_line", ql(p0_line, 0), {32'd4, 32'd3, 32'd2, 32'd1});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
